// File: rtl/dispatch_controller_pkg.sv
// Shared types for the dispatch controller: unit class codes, FSM states,
// GPR write-port owner and fault cause encodings.
package dispatch_controller_pkg;

  localparam logic [2:0] CLS_ALU  = 3'b100;
  localparam logic [2:0] CLS_PFCU = 3'b110;
  localparam logic [2:0] CLS_MIO  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_RETIRE = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    GPR_NONE = 2'd0,
    GPR_ALU  = 2'd1,
    GPR_MIO  = 2'd2
  } gpr_sel_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ILLEGAL = 2'd1,
    FC_TIMEOUT = 2'd2
  } fault_code_e;

  function automatic logic is_legal_class(input logic [2:0] cls);
    return (cls == CLS_ALU) || (cls == CLS_PFCU) || (cls == CLS_MIO);
  endfunction

endpackage

// File: rtl/dispatch_controller_if.sv
// Decoder/unit-side bus of the dispatch controller plus a debug view of the FSM state.
interface dispatch_controller_if
  import dispatch_controller_pkg::*;
  #(parameter int RET_W = 32);

  // Handshake: inst_pres is the decoder's "valid"; rq_nxt_inst is a one-cycle
  // "ready" pulse that consumes the current instruction. Each unit enable is
  // held until that unit's done strobe is seen, which ends the transaction.
  logic             inst_pres;
  logic [2:0]       inst_class;
  logic             alu_done;
  logic             pfcu_done;
  logic             mio_done;
  logic             alu_en;
  logic             pfcu_en;
  logic             mio_en;
  logic             rq_nxt_inst;
  logic [1:0]       gpr_sel;
  logic             busy;
  logic             fault;
  logic [1:0]       fault_code;
  logic [RET_W-1:0] retired;
  state_e           dbg_state;

  modport master (
    output inst_pres, inst_class, alu_done, pfcu_done, mio_done,
    input  alu_en, pfcu_en, mio_en, rq_nxt_inst, gpr_sel, busy, fault,
           fault_code, retired, dbg_state
  );

  modport slave (
    input  inst_pres, inst_class, alu_done, pfcu_done, mio_done,
    output alu_en, pfcu_en, mio_en, rq_nxt_inst, gpr_sel, busy, fault,
           fault_code, retired, dbg_state
  );

endinterface

// File: rtl/dispatch_controller_watchdog.sv
// EXEC-phase watchdog: counts enabled cycles since the last clear and flags
// the TIMEOUT-th one.
module dispatch_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds (EXEC cycle index - 1), so this fires during the TIMEOUT-th cycle.
  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/dispatch_controller.sv
// Single-issue dispatch FSM: routes the decoder's instruction to ALU/PFCU/M&IO,
// waits for completion, retires it and requests the next one.
module dispatch_controller
  import dispatch_controller_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int RET_W   = 32
) (
  input logic                 clk,
  input logic                 rst,
  dispatch_controller_if.slave bus
);

  state_e           state_q, state_d;
  logic [2:0]       cls_q, cls_d;
  fault_code_e      fcode_q, fcode_d;
  logic             sel_done;
  logic             wd_expired;

  logic             alu_en_q, pfcu_en_q, mio_en_q, rq_q, busy_q, fault_q;
  gpr_sel_e         gpr_q;
  logic [RET_W-1:0] retired_q;

  dispatch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == ST_IDLE),
    .enable  (state_q == ST_EXEC),
    .expired (wd_expired)
  );

  always_comb begin
    sel_done = 1'b0;
    case (cls_q)
      CLS_ALU:  sel_done = bus.alu_done;
      CLS_PFCU: sel_done = bus.pfcu_done;
      CLS_MIO:  sel_done = bus.mio_done;
      default:  sel_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    fcode_d = fcode_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.inst_pres) begin
          if (is_legal_class(bus.inst_class)) begin
            state_d = ST_EXEC;
            cls_d   = bus.inst_class;
          end else begin
            state_d = ST_FAULT;
            fcode_d = FC_ILLEGAL;
          end
        end
      end
      ST_EXEC: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (sel_done) begin
          state_d = ST_RETIRE;
        end else if (wd_expired) begin
          state_d = ST_FAULT;
          fcode_d = FC_TIMEOUT;
        end
      end
      ST_RETIRE: state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cls_q   <= '0;
      fcode_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      fcode_q <= fcode_d;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_en_q  <= 1'b0;
      pfcu_en_q <= 1'b0;
      mio_en_q  <= 1'b0;
      rq_q      <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      gpr_q     <= GPR_NONE;
      retired_q <= '0;
    end else begin
      alu_en_q  <= (state_d == ST_EXEC) && (cls_d == CLS_ALU);
      pfcu_en_q <= (state_d == ST_EXEC) && (cls_d == CLS_PFCU);
      mio_en_q  <= (state_d == ST_EXEC) && (cls_d == CLS_MIO);
      rq_q      <= (state_d == ST_RETIRE);
      busy_q    <= (state_d != ST_IDLE);
      fault_q   <= (state_d == ST_FAULT);
      if (state_d == ST_EXEC && cls_d == CLS_ALU) begin
        gpr_q <= GPR_ALU;
      end else if (state_d == ST_EXEC && cls_d == CLS_MIO) begin
        gpr_q <= GPR_MIO;
      end else begin
        gpr_q <= GPR_NONE;
      end
      if (state_d == ST_RETIRE) begin
        retired_q <= retired_q + RET_W'(1);
      end
    end
  end

  assign bus.alu_en      = alu_en_q;
  assign bus.pfcu_en     = pfcu_en_q;
  assign bus.mio_en      = mio_en_q;
  assign bus.rq_nxt_inst = rq_q;
  assign bus.gpr_sel     = gpr_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = fcode_q;
  assign bus.retired     = retired_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_dispatch_controller.sv
// Directed bench for dispatch_controller: a default instance and a
// TIMEOUT=4 / RET_W=4 instance share clock and reset.
module tb_dispatch_controller;
  import dispatch_controller_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dispatch_controller_if #(.RET_W(32)) a_if ();
  dispatch_controller_if #(.RET_W(4))  b_if ();

  dispatch_controller #(.TIMEOUT(256), .RET_W(32)) dut_a (
    .clk (clk), .rst (rst), .bus (a_if.slave)
  );

  dispatch_controller #(.TIMEOUT(4), .RET_W(4)) dut_b (
    .clk (clk), .rst (rst), .bus (b_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, ".en"}, {29'd0, a_if.alu_en, a_if.pfcu_en, a_if.mio_en}, 32'd0);
    chk({tag, ".rq"}, {31'd0, a_if.rq_nxt_inst}, 32'd0);
    chk({tag, ".gpr"}, {30'd0, a_if.gpr_sel}, 32'd0);
    chk({tag, ".busy"}, {31'd0, a_if.busy}, 32'd0);
    chk({tag, ".fault"}, {29'd0, a_if.fault, a_if.fault_code}, 32'd0);
    chk({tag, ".ret"}, a_if.retired, 32'd0);
  endtask

  initial begin
    int exp_ret;
    checks = 0;
    errors = 0;
    {a_if.inst_pres, a_if.alu_done, a_if.pfcu_done, a_if.mio_done} = '0;
    {b_if.inst_pres, b_if.alu_done, b_if.pfcu_done, b_if.mio_done} = '0;
    a_if.inst_class = 3'b000;
    b_if.inst_class = 3'b000;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk_a_zero("reset_a");
    chk("reset_b.ret", {28'd0, b_if.retired}, 32'd0);
    chk("reset_b.fault", {31'd0, b_if.fault}, 32'd0);

    // ALU, done in first EXEC cycle
    a_if.inst_pres = 1'b1; a_if.inst_class = CLS_ALU;
    step();
    chk("alu.en", {29'd0, a_if.alu_en, a_if.pfcu_en, a_if.mio_en}, 32'd4);
    chk("alu.gpr", {30'd0, a_if.gpr_sel}, 32'd1);
    chk("alu.rq_exec", {31'd0, a_if.rq_nxt_inst}, 32'd0);
    chk("alu.busy", {31'd0, a_if.busy}, 32'd1);
    a_if.inst_pres = 1'b0; a_if.alu_done = 1'b1;
    step();
    a_if.alu_done = 1'b0;
    chk("alu.rq", {31'd0, a_if.rq_nxt_inst}, 32'd1);
    chk("alu.en_ret", {29'd0, a_if.alu_en, a_if.pfcu_en, a_if.mio_en}, 32'd0);
    chk("alu.gpr_ret", {30'd0, a_if.gpr_sel}, 32'd0);
    chk("alu.retired", a_if.retired, 32'd1);
    step();
    chk("alu.rq_idle", {31'd0, a_if.rq_nxt_inst}, 32'd0);
    chk("alu.busy_idle", {31'd0, a_if.busy}, 32'd0);

    // M&IO, 5 EXEC cycles, stray alu_done and class change ignored
    do_reset();
    a_if.inst_pres = 1'b1; a_if.inst_class = CLS_MIO;
    step();
    a_if.inst_pres = 1'b0; a_if.inst_class = CLS_ALU;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("mio.en_c%0d", k), {29'd0, a_if.alu_en, a_if.pfcu_en, a_if.mio_en}, 32'd1);
      chk($sformatf("mio.gpr_c%0d", k), {30'd0, a_if.gpr_sel}, 32'd2);
      a_if.alu_done = (k == 3);
      a_if.mio_done = (k == 5);
      step();
    end
    a_if.alu_done = 1'b0; a_if.mio_done = 1'b0;
    chk("mio.rq", {31'd0, a_if.rq_nxt_inst}, 32'd1);
    chk("mio.en_ret", {29'd0, a_if.alu_en, a_if.pfcu_en, a_if.mio_en}, 32'd0);
    chk("mio.retired", a_if.retired, 32'd1);
    step();

    // illegal class
    do_reset();
    a_if.inst_pres = 1'b1; a_if.inst_class = 3'b111;
    step();
    a_if.inst_pres = 1'b0;
    chk("ill.fault", {31'd0, a_if.fault}, 32'd1);
    chk("ill.code", {30'd0, a_if.fault_code}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ill.en_%0d", k), {29'd0, a_if.alu_en, a_if.pfcu_en, a_if.mio_en}, 32'd0);
      chk($sformatf("ill.hold_%0d", k), {29'd0, a_if.fault, a_if.fault_code}, 32'd5);
      chk($sformatf("ill.rq_%0d", k), {31'd0, a_if.rq_nxt_inst}, 32'd0);
      a_if.inst_pres = 1'b1; a_if.inst_class = CLS_ALU; a_if.alu_done = 1'b1;
      step();
    end
    a_if.inst_pres = 1'b0; a_if.alu_done = 1'b0;
    do_reset();
    chk_a_zero("ill_rst");

    // reset mid-EXEC, held reset, then normal dispatch
    a_if.inst_pres = 1'b1; a_if.inst_class = CLS_ALU;
    step();
    a_if.inst_pres = 1'b0;
    step();
    chk("rstx.en_c2", {29'd0, a_if.alu_en, a_if.pfcu_en, a_if.mio_en}, 32'd4);
    rst = 1'b1;
    step();
    chk_a_zero("rstx");
    a_if.inst_pres = 1'b1;
    step();
    chk_a_zero("rstx_hold");
    rst = 1'b0;
    step();
    a_if.inst_pres = 1'b0; a_if.alu_done = 1'b1;
    chk("rstx.redispatch", {29'd0, a_if.alu_en, a_if.pfcu_en, a_if.mio_en}, 32'd4);
    step();
    a_if.alu_done = 1'b0;
    chk("rstx.rq", {31'd0, a_if.rq_nxt_inst}, 32'd1);
    chk("rstx.retired", a_if.retired, 32'd1);
    step();

    // TIMEOUT=4 PFCU, no done -> timeout fault
    do_reset();
    b_if.inst_pres = 1'b1; b_if.inst_class = CLS_PFCU;
    step();
    b_if.inst_pres = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("to.en_c%0d", k), {29'd0, b_if.alu_en, b_if.pfcu_en, b_if.mio_en}, 32'd2);
      chk($sformatf("to.gpr_c%0d", k), {30'd0, b_if.gpr_sel}, 32'd0);
      chk($sformatf("to.nofault_c%0d", k), {31'd0, b_if.fault}, 32'd0);
      step();
    end
    chk("to.fault", {29'd0, b_if.fault, b_if.fault_code}, 32'd6);
    chk("to.en", {29'd0, b_if.alu_en, b_if.pfcu_en, b_if.mio_en}, 32'd0);

    // TIMEOUT=4 PFCU, done on cycle 4 wins
    do_reset();
    b_if.inst_pres = 1'b1; b_if.inst_class = CLS_PFCU;
    step();
    b_if.inst_pres = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      b_if.pfcu_done = (k == 4);
      step();
    end
    b_if.pfcu_done = 1'b0;
    chk("to4.rq", {31'd0, b_if.rq_nxt_inst}, 32'd1);
    chk("to4.fault", {29'd0, b_if.fault, b_if.fault_code}, 32'd0);
    chk("to4.retired", {28'd0, b_if.retired}, 32'd1);
    step();

    // RET_W=4 wrap over 17 instructions
    do_reset();
    exp_ret = 0;
    for (int i = 0; i < 17; i++) begin
      b_if.inst_pres = 1'b1; b_if.inst_class = CLS_ALU;
      step();
      b_if.inst_pres = 1'b0; b_if.alu_done = 1'b1;
      step();
      b_if.alu_done = 1'b0;
      exp_ret = (exp_ret + 1) % 16;
      chk($sformatf("wrap.ret_%0d", i), {28'd0, b_if.retired}, exp_ret);
      step();
    end
    chk("wrap.final", {28'd0, b_if.retired}, 32'd1);
    chk("wrap.fault", {31'd0, b_if.fault}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_controller.md
DISPATCH_CONTROLLER -- requirements
Module: dispatch_controller

Interface
REQ-001 Parameter TIMEOUT, default 256, SHALL set the maximum cycles in EXEC before a fault (legal range 2..65535).
REQ-002 Parameter RET_W, default 32, SHALL set the retired-instruction counter width.
REQ-003 clk  in  1  SHALL be the single core clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 inst_pres  in  1  SHALL indicate that the decoder holds a valid current instruction.
REQ-006 inst_class  in  3  SHALL carry the instruction unit class, i.e. instruction bits [2:0].
REQ-007 alu_done, pfcu_done, mio_done  in  1 each  SHALL be completion strobes from the ALU, PFCU and M&IO units.
REQ-008 alu_en, pfcu_en, mio_en  out  1 each  SHALL be unit enables, registered, at most one high at a time.
REQ-009 rq_nxt_inst  out  1  SHALL be a one-cycle registered pulse requesting the next instruction from the decoder.
REQ-010 gpr_sel  out  2  SHALL be the GPR write-port owner: 0 none, 1 ALU, 2 M&IO; value 3 is never driven.
REQ-011 busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-012 fault  out  1  SHALL be a sticky error flag.
REQ-013 fault_code  out  2  SHALL report the fault cause: 0 none, 1 illegal class, 2 timeout.
REQ-014 retired  out  RET_W  SHALL count retired instructions.

Function
REQ-015 The state machine SHALL have exactly four states: IDLE, EXEC, RETIRE and FAULT.
REQ-016 IDLE with inst_pres=1 and a legal class SHALL move to EXEC, with the matching enable high from the next cycle.
  - Legal classes: 3'b100 ALU, 3'b110 PFCU, 3'b010 M&IO.
REQ-017 IDLE with inst_pres=1 and an illegal class SHALL move to FAULT, with fault=1 and fault_code=1.
REQ-018 IDLE with inst_pres=0 SHALL remain in IDLE with all enables low.
REQ-019 The class SHALL be latched on dispatch; changes on inst_class or inst_pres during EXEC SHALL be ignored.
REQ-020 In EXEC:
  - the latched unit's enable SHALL stay high;
  - gpr_sel SHALL be 1 (ALU), 2 (M&IO) or 0 (PFCU).
REQ-021 In EXEC, the latched unit's done=1 SHALL move to RETIRE. done from non-selected units SHALL be ignored.
REQ-022 In RETIRE (one cycle):
  - all enables low and gpr_sel=0;
  - rq_nxt_inst=1 and retired increments by 1;
  - next state IDLE.
REQ-023 retired SHALL wrap modulo 2^RET_W without any flag.
REQ-024 The watchdog SHALL:
  - clear on entry to EXEC and increment each EXEC cycle;
  - on the TIMEOUT-th EXEC cycle without done, move to FAULT with fault_code=2.
REQ-025 When done and timeout expiry occur in the same cycle, done SHALL win (go to RETIRE, no fault).
REQ-026 FAULT SHALL hold all enables low, rq_nxt_inst=0 and gpr_sel=0, and SHALL exit only on reset.
REQ-027 Minimum dispatch-to-next-request latency SHALL be 3 cycles when done arrives in the first EXEC cycle.
REQ-028 rq_nxt_inst SHALL never be asserted in IDLE, EXEC or FAULT.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE, including mid-EXEC.
REQ-030 On that edge, every output SHALL go to 0: enables, rq_nxt_inst, gpr_sel, busy, fault, fault_code and retired.
REQ-031 The watchdog and the latched class SHALL clear on reset; rst held high SHALL keep all outputs at 0.

Structure
REQ-032 The following SHALL live in the shared structs/defines package:
  - unit class codes;
  - the state enum;
  - the gpr_sel enum;
  - the fault_code enum.
REQ-033 The watchdog SHALL be a separate sub-module, dispatch_watchdog, with clear, enable and expired ports, parameterised by TIMEOUT.

Verification
REQ-034 Reset then inst_pres=1, class=3'b100, alu_done at EXEC cycle 1 -> alu_en high 1 cycle, gpr_sel=1, rq_nxt_inst pulse at cycle 3, retired=1.
REQ-035 class=3'b010, mio_done after 5 EXEC cycles, alu_done pulsed meanwhile -> alu_done ignored, mio_en high 5 cycles, gpr_sel=2, retired=1.
REQ-036 class=3'b111 -> fault=1, fault_code=1 the next cycle, no enable ever high, stays until rst.
REQ-037 TIMEOUT=4, class=3'b110, no done -> pfcu_en high 4 cycles, then fault_code=2; a second run with done on cycle 4 -> RETIRE, no fault.
REQ-038 rst asserted on EXEC cycle 2 of an ALU instruction -> all outputs 0 next edge; a new dispatch then proceeds normally.
REQ-039 RET_W=4, 17 back-to-back ALU instructions -> retired wraps to 1, no fault.
